// File: rtl/soc_fpga_ram_code_loader_pkg.sv
// rtl/soc_fpga_ram_code_loader_pkg.sv - shared state encodings and default RAM geometry for the code loader
//
// Purpose: single place for the loader state encoding and the default
// DATAWIDTH / ADDRWIDTH that the code RAM instances are built with.
package soc_fpga_ram_code_loader_pkg;

    localparam int DEF_DATAWIDTH = 32;
    localparam int DEF_ADDRWIDTH = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } loader_state_e;

endpackage

// File: rtl/soc_fpga_ram_code_loader_if.sv
// rtl/soc_fpga_ram_code_loader_if.sv - byte stream and code RAM Port A bundle for the loader
//
// Purpose: groups the host byte stream handshake and the RAM port signals.
// Signals:
//   ByteValid/ByteData/ByteReady          host byte stream (valid/ready)
//   RamAddr/RamDataIn/RamWriteEnable      RAM command side, driven by the loader
//   RamDataOut                            RAM read data, one cycle after the address
// Modports: master = loader side, slave = host stream source plus RAM.
interface soc_fpga_ram_code_loader_if
    import soc_fpga_ram_code_loader_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ADDRWIDTH = DEF_ADDRWIDTH
);
    logic                 ByteValid;
    logic [7:0]           ByteData;
    logic                 ByteReady;
    logic [ADDRWIDTH-1:0] RamAddr;
    logic [DATAWIDTH-1:0] RamDataIn;
    logic                 RamWriteEnable;
    logic [DATAWIDTH-1:0] RamDataOut;

    modport master (
        input  ByteValid, ByteData, RamDataOut,
        output ByteReady, RamAddr, RamDataIn, RamWriteEnable
    );

    modport slave (
        output ByteValid, ByteData, RamDataOut,
        input  ByteReady, RamAddr, RamDataIn, RamWriteEnable
    );
endinterface

// File: rtl/soc_fpga_ram_code_loader_byte_packer.sv
// rtl/soc_fpga_ram_code_loader_byte_packer.sv - little-endian byte to word packer with lane counter
//
// Purpose: collects accepted bytes into a DATAWIDTH word, first byte in bits [7:0].
// Ports:
//   clk_i         clock
//   clear_i       synchronous clear of lane counter and partial word
//   byte_fire_i   a byte is transferred this cycle
//   byte_data_i   the byte
//   word_valid_o  high in the cycle the last lane is accepted
//   word_o        complete word including the byte accepted this cycle
module soc_fpga_byte_packer #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 clear_i,
    input  logic                 byte_fire_i,
    input  logic [7:0]           byte_data_i,
    output logic                 word_valid_o,
    output logic [DATAWIDTH-1:0] word_o
);
    localparam int BYTES = DATAWIDTH / 8;
    localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [LW-1:0]        lane_q, lane_d;
    logic [DATAWIDTH-1:0] word_q, word_d;
    logic                 last_lane;

    always_comb begin
        word_d    = word_q;
        lane_d    = lane_q;
        last_lane = (int'(lane_q) == BYTES - 1);
        if (byte_fire_i) begin
            word_d[8*lane_q +: 8] = byte_data_i;
            lane_d = last_lane ? '0 : lane_q + 1'b1;
        end
    end

    // The word is presented combinationally so the loader can register the
    // RAM write on the same edge that accepts the last byte.
    assign word_valid_o = byte_fire_i && last_lane;
    assign word_o       = word_d;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/soc_fpga_ram_code_loader.sv
// rtl/soc_fpga_ram_code_loader.sv - loads a byte stream into the code RAM and checksums it on read-back
//
// Purpose: packs host bytes into words, writes words 0..N-1, reads them all
// back and sums them modulo 2^DATAWIDTH.
// Ports:
//   Clk, Rst     clock, synchronous active-high reset
//   Start        load request pulse, ignored while Busy
//   WordCount    words to load, clamped to the RAM depth
//   bus          byte stream and RAM Port A (master side)
//   Busy, Done   activity flag and one-cycle completion pulse
//   Checksum     read-back sum, held until the next accepted Start
module soc_fpga_ram_code_loader
    import soc_fpga_ram_code_loader_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Start,
    input  logic [ADDRWIDTH:0]             WordCount,
    soc_fpga_ram_code_loader_if.master     bus,
    output logic                           Busy,
    output logic                           Done,
    output logic [DATAWIDTH-1:0]           Checksum
);
    localparam logic [ADDRWIDTH:0] DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};

    loader_state_e        state_q, state_d;
    logic [ADDRWIDTH:0]   n_q, n_d;
    logic [ADDRWIDTH:0]   widx_q, widx_d;
    logic                 ready_q, ready_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0] din_q, din_d;
    logic                 we_q, we_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DATAWIDTH-1:0] sum_q, sum_d;
    logic                 rd_issued_q, rd_issued_d;
    logic                 rd_valid_q;

    logic                 start_accept;
    logic                 byte_fire;
    logic                 word_valid;
    logic [DATAWIDTH-1:0] word;

    assign byte_fire = bus.ByteValid && ready_q;

    soc_fpga_byte_packer #(.DATAWIDTH(DATAWIDTH)) u_packer (
        .clk_i        (Clk),
        .clear_i      (Rst || start_accept),
        .byte_fire_i  (byte_fire),
        .byte_data_i  (bus.ByteData),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        widx_d       = widx_q;
        ready_d      = ready_q;
        addr_d       = addr_q;
        din_d        = din_q;
        we_d         = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_issued_d  = 1'b0;
        start_accept = 1'b0;
        sum_d        = sum_q;

        // Read data lags its address by one RAM cycle; the accumulator runs
        // off the delayed flag regardless of state so DRAIN/DONE pick up the tail.
        if (rd_valid_q) begin
            sum_d = sum_q + bus.RamDataOut;
        end

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    start_accept = 1'b1;
                    n_d          = (WordCount > DEPTH) ? DEPTH : WordCount;
                    sum_d        = '0;
                    busy_d       = 1'b1;
                    widx_d       = '0;
                    if (n_d == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                        ready_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    we_d   = 1'b1;
                    addr_d = widx_q[ADDRWIDTH-1:0];
                    din_d  = word;
                    if (widx_q == n_q - 1'b1) begin
                        widx_d  = '0;
                        ready_d = 1'b0;
                        state_d = ST_VERIFY;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                addr_d      = widx_q[ADDRWIDTH-1:0];
                rd_issued_d = 1'b1;
                if (widx_q == n_q - 1'b1) begin
                    widx_d  = '0;
                    state_d = ST_DRAIN;
                end else begin
                    widx_d = widx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            widx_q      <= '0;
            ready_q     <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= '0;
            rd_issued_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            widx_q      <= widx_d;
            ready_q     <= ready_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sum_q       <= sum_d;
            rd_issued_q <= rd_issued_d;
            rd_valid_q  <= rd_issued_q;
        end
    end

    assign bus.ByteReady      = ready_q;
    assign bus.RamAddr        = addr_q;
    assign bus.RamDataIn      = din_q;
    assign bus.RamWriteEnable = we_q;
    assign Busy               = busy_q;
    assign Done               = done_q;
    assign Checksum           = sum_q;
endmodule

// File: tb/tb_soc_fpga_ram_code_loader.sv
// tb/tb_soc_fpga_ram_code_loader.sv - self-checking bench for the code RAM loader
module tb_soc_fpga_ram_code_loader;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Start;
    logic [AW:0]   WordCount;
    logic          Busy;
    logic          Done;
    logic [DW-1:0] Checksum;

    soc_fpga_ram_code_loader_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

    soc_fpga_ram_code_loader #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .WordCount (WordCount),
        .bus       (bus),
        .Busy      (Busy),
        .Done      (Done),
        .Checksum  (Checksum)
    );

    always #5 Clk = ~Clk;

    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            n_fire = 0;
    logic [7:0]    stim [0:127];

    int n_cmp = 0;
    int n_err = 0;
    int run_id = 0;

    always @(posedge Clk) begin
        if (bus.RamWriteEnable) begin
            ram[bus.RamAddr] <= bus.RamDataIn;
            wr_addr_q.push_back(bus.RamAddr);
            wr_data_q.push_back(bus.RamDataIn);
        end
        bus.RamDataOut <= ram[bus.RamAddr];
        if (bus.ByteValid && bus.ByteReady && !Rst) n_fire <= n_fire + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    64'(bus.ByteReady),      64'd0);
        check({tag, "_addr"},     64'(bus.RamAddr),        64'd0);
        check({tag, "_din"},      64'(bus.RamDataIn),      64'd0);
        check({tag, "_we"},       64'(bus.RamWriteEnable), 64'd0);
        check({tag, "_busy"},     64'(Busy),               64'd0);
        check({tag, "_done"},     64'(Done),               64'd0);
        check({tag, "_checksum"}, 64'(Checksum),           64'd0);
    endtask

    // gap_mode: 0 = ByteValid always high, 1 = 1,0,1,0..., 2 = random.
    // poke: pulse Start again while the load is in progress.
    task automatic run_load(input int wc, input int gap_mode, input bit poke);
        int            n, nbytes, idx, cyc, lat, fire_base, wr_base;
        logic          fire, v;
        logic [DW-1:0] exp_word [DEPTH];
        logic [DW-1:0] exp_sum;
        string         t;

        run_id++;
        t = $sformatf("run%0d", run_id);
        n = (wc > DEPTH) ? DEPTH : wc;
        nbytes = 4 * n;

        exp_sum = '0;
        for (int k = 0; k < n; k++) begin
            exp_word[k] = '0;
            for (int b = 0; b < 4; b++) exp_word[k] |= DW'(stim[4*k+b]) << (8*b);
            exp_sum += exp_word[k];
        end

        fire_base = n_fire;
        wr_base   = wr_addr_q.size();

        // A byte offered in the Start cycle must not be consumed.
        @(negedge Clk);
        Start = 1'b1;
        WordCount = (AW+1)'(wc);
        bus.ByteValid = 1'b1;
        bus.ByteData  = 8'hEE;
        @(posedge Clk);

        idx = 0;
        cyc = 0;
        while (idx < nbytes && cyc < 8 * nbytes + 50) begin
            @(negedge Clk);
            cyc++;
            Start = 1'b0;
            if (poke && idx >= 5 && idx < 7) begin
                Start = 1'b1;
                WordCount = (AW+1)'(1);
            end
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 1);
                default: v = 1'(($urandom_range(0, 1)));
            endcase
            bus.ByteValid = v;
            bus.ByteData  = v ? stim[idx] : 8'($urandom);
            #4;
            fire = bus.ByteValid && bus.ByteReady;
            @(posedge Clk);
            if (fire) idx++;
        end
        check({t, "_bytes_sent"}, 64'(idx), 64'(nbytes));

        // Keep offering data after the last byte; none of it may be taken.
        @(negedge Clk);
        Start = 1'b0;
        bus.ByteValid = 1'b1;
        bus.ByteData  = 8'($urandom);
        check({t, "_ready_low"}, 64'(bus.ByteReady), 64'd0);
        lat = 0;
        while (!Done && lat < 100) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        check({t, "_latency"}, 64'(lat), (n == 0) ? 64'd1 : 64'(n + 2));
        check({t, "_busy_at_done"}, 64'(Busy), 64'd0);
        check({t, "_checksum"}, 64'(Checksum), 64'(exp_sum));
        @(negedge Clk);
        bus.ByteValid = 1'b0;
        check({t, "_done_pulse"}, 64'(Done), 64'd0);
        check({t, "_busy_after"}, 64'(Busy), 64'd0);
        check({t, "_fires"}, 64'(n_fire - fire_base), 64'(nbytes));
        check({t, "_writes"}, 64'(wr_addr_q.size() - wr_base), 64'(n));
        for (int k = 0; k < n && wr_base + k < wr_addr_q.size(); k++) begin
            check($sformatf("%s_wr_addr%0d", t, k), 64'(wr_addr_q[wr_base+k]), 64'(k));
            check($sformatf("%s_wr_data%0d", t, k), 64'(wr_data_q[wr_base+k]), 64'(exp_word[k]));
        end
        for (int k = 0; k < n; k++)
            check($sformatf("%s_ram%0d", t, k), 64'(ram[k]), 64'(exp_word[k]));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        Rst = 1'b1;
        Start = 1'b0;
        WordCount = '0;
        bus.ByteValid = 1'b0;
        bus.ByteData  = 8'h00;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("reset");
        Rst = 1'b0;

        // N=2, bytes 01..08 back to back.
        for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
        run_load(2, 0, 1'b0);
        check("tp1_ram0", 64'(ram[0]), 64'h04030201);
        check("tp1_ram1", 64'(ram[1]), 64'h08070605);
        check("tp1_sum",  64'(Checksum), 64'h0C0A0806);

        // Empty load.
        run_load(0, 0, 1'b0);
        check("tp2_sum", 64'(Checksum), 64'd0);

        // N=3, gap-free then toggling valid with the same bytes.
        for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
        run_load(3, 0, 1'b0);
        run_load(3, 1, 1'b0);

        // Clamp: 20 words requested, 16 written.
        for (int i = 0; i < 4 * DEPTH; i++) stim[i] = 8'($urandom);
        run_load(20, 0, 1'b0);

        // Reset after 5 bytes of a load.
        @(negedge Clk);
        Start = 1'b1;
        WordCount = (AW+1)'(2);
        @(posedge Clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            Start = 1'b0;
            bus.ByteValid = 1'b1;
            bus.ByteData  = 8'($urandom);
            @(posedge Clk);
        end
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("midrst");
        Rst = 1'b0;
        bus.ByteValid = 1'b0;
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD;
        run_load(1, 0, 1'b0);
        check("tp5_ram0", 64'(ram[0]), 64'hDDCCBBAA);

        // Start pulsed during LOAD must be ignored.
        for (int i = 0; i < 24; i++) stim[i] = 8'($urandom);
        run_load(6, 0, 1'b1);

        // Randomised loads.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4 * DEPTH; i++) stim[i] = 8'($urandom);
            run_load(int'($urandom_range(0, 20)), 2, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
